// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side controller and its 2-entry skid buffer.
package fifo_rd_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned OCC_W         = 2;

  // Encoding doubles as the buffered word count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_state_e;

  function automatic logic [OCC_W-1:0] occ_of(input skid_state_e s);
    return OCC_W'(s);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry skid buffer: head is the oldest word, tail is promoted to head on a pop.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output skid_state_e      o_state
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  skid_state_e      r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (i_push) begin
            r_head  <= i_push_data;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (i_push && i_pop) begin
            r_head <= i_push_data;
          end else if (i_push) begin
            r_tail  <= i_push_data;
            r_state <= S_TWO;
          end else if (i_pop) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          // Upstream flow control never pushes into a full buffer without a pop.
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) begin
              r_tail <= i_push_data;
            end else begin
              r_state <= S_ONE;
            end
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_state = r_state;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for an async FIFO: issues pops, tracks the returning word, feeds a skid buffer.
// Optional transfer counter output rd_cnt is built when FIFO_RD_CNT_EN is defined.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0] rd_cnt
`endif
);

  logic             r_inflight;
  skid_state_e      w_state;
  logic [WIDTH-1:0] w_head;
  logic [1:0]       w_occ;
  logic [2:0]       w_load;
  logic             w_transfer;
  logic             w_capture;

  assign w_occ      = occ_of(w_state);
  assign w_load     = 3'(w_occ) + 3'(r_inflight);
  assign out_valid  = ~rst & (w_state != S_EMPTY);
  assign out_data   = rst ? '0 : w_head;
  assign w_transfer = out_valid & out_ready;
  assign w_capture  = r_inflight;

  // A pop is allowed when a slot is guaranteed free once the in-flight word lands.
  assign fifo_rd_en = ~fifo_empty & ~rst & ((w_load < 3'd2) | w_transfer);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
    end
  end

  fifo_rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_capture),
    .i_push_data (fifo_rd_data),
    .i_pop       (w_transfer),
    .o_head      (w_head),
    .o_state     (w_state)
  );

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] r_rd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= '0;
    end else if (w_transfer) begin
      r_rd_cnt <= r_rd_cnt + CNT_W'(1);
    end
  end

  assign rd_cnt = r_rd_cnt;
`else
  localparam int unsigned CNT_W_UNUSED = CNT_W;
`endif

endmodule
